// File: rtl/issue_select_multi.sv
// Multi-issue select stage: picks up to ISSUE_WIDTH ready stations oldest-first by ROB age,
// with load/store ordering and memory ops confined to slot 0. Define ISSUE_PERF_EN for perf counters.
module issue_select_multi #(
  parameter int ISSUE_WIDTH = 2,
  parameter int RS_SIZE     = 8,
  parameter int ROB_SIZE    = 16,
  parameter int LSQ_SIZE    = 8,
  parameter int RS_W        = $clog2(RS_SIZE),
  parameter int TAG_W       = $clog2(ROB_SIZE),
  parameter int LSQ_W       = $clog2(LSQ_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [RS_SIZE-1:0]           rs_ready,
  input  logic [RS_SIZE*TAG_W-1:0]     rs_tag,
  input  logic [RS_SIZE*LSQ_W-1:0]     rs_lsq_id,
  input  logic [RS_SIZE-1:0]           rs_is_load,
  input  logic [RS_SIZE-1:0]           rs_is_store,
  input  logic [TAG_W-1:0]             rob_head,
  input  logic [ROB_SIZE-1:0]          rob_ctrl_mask,
  input  logic [LSQ_W-1:0]             lsq_head,
  input  logic [LSQ_SIZE-1:0]          lsq_store_mask,
  input  logic [ISSUE_WIDTH-1:0]       iss_ready,
  output logic [ISSUE_WIDTH-1:0]       iss_valid,
  output logic [ISSUE_WIDTH*RS_W-1:0]  iss_rs_id,
  output logic [ISSUE_WIDTH*TAG_W-1:0] iss_tag,
  output logic [ISSUE_WIDTH*LSQ_W-1:0] iss_lsq_id,
  output logic [RS_SIZE-1:0]           rs_grant,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall
);

  logic [ISSUE_WIDTH-1:0] iss_valid_q, iss_valid_d;
  logic [RS_W-1:0]        iss_rs_id_q  [ISSUE_WIDTH];
  logic [RS_W-1:0]        iss_rs_id_d  [ISSUE_WIDTH];
  logic [TAG_W-1:0]       iss_tag_q    [ISSUE_WIDTH];
  logic [TAG_W-1:0]       iss_tag_d    [ISSUE_WIDTH];
  logic [LSQ_W-1:0]       iss_lsq_id_q [ISSUE_WIDTH];
  logic [LSQ_W-1:0]       iss_lsq_id_d [ISSUE_WIDTH];
  logic [RS_SIZE-1:0]     rs_grant_q, rs_grant_d;

  logic [TAG_W-1:0]       age [RS_SIZE];
  logic [RS_SIZE-1:0]     alu_elig, mem_elig;
  logic [ISSUE_WIDTH-1:0] slot_free, sel_valid;
  logic [RS_W-1:0]        sel_id  [ISSUE_WIDTH];
  logic [TAG_W-1:0]       sel_tag [ISSUE_WIDTH];
  logic [LSQ_W-1:0]       sel_lsq [ISSUE_WIDTH];

  assign slot_free = ~iss_valid_q | iss_ready;

  // Ages and eligibility are all measured relative to the ROB/LSQ heads so wrap-around is free.
  always_comb begin
    logic [TAG_W-1:0] tag_i, age_i, age_t;
    logic [LSQ_W-1:0] lsq_i, dist_i, dist_j;
    logic             ctrl_blk, st_blk, cand;
    alu_elig = '0;
    mem_elig = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      tag_i    = rs_tag[i*TAG_W +: TAG_W];
      lsq_i    = rs_lsq_id[i*LSQ_W +: LSQ_W];
      age_i    = tag_i - rob_head;
      dist_i   = lsq_i - lsq_head;
      age[i]   = age_i;
      ctrl_blk = 1'b0;
      st_blk   = 1'b0;
      for (int t = 0; t < ROB_SIZE; t++) begin
        age_t = TAG_W'(t) - rob_head;
        if (rob_ctrl_mask[t] && (age_t < age_i)) ctrl_blk = 1'b1;
      end
      for (int j = 0; j < LSQ_SIZE; j++) begin
        dist_j = LSQ_W'(j) - lsq_head;
        if (lsq_store_mask[j] && (dist_j < dist_i)) st_blk = 1'b1;
      end
      cand = rs_ready[i] && !rs_grant_q[i];
      if (rs_is_store[i])
        mem_elig[i] = cand && !ctrl_blk && (lsq_i == lsq_head);
      else if (rs_is_load[i])
        mem_elig[i] = cand && !ctrl_blk && !st_blk;
      else
        alu_elig[i] = cand;
    end
  end

  // Slot 0 competes memory ops against ALU ops by age; later slots only see remaining ALU ops.
  always_comb begin
    logic [RS_SIZE-1:0] pool, pool_k;
    logic               found;
    int                 best;
    logic [TAG_W-1:0]   best_age;
    pool       = alu_elig;
    sel_valid  = '0;
    rs_grant_d = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      sel_id[k]  = '0;
      sel_tag[k] = '0;
      sel_lsq[k] = '0;
      pool_k     = pool;
      if (k == 0) pool_k = pool | mem_elig;
      found    = 1'b0;
      best     = 0;
      best_age = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (pool_k[i] && (!found || (age[i] < best_age))) begin
          found    = 1'b1;
          best     = i;
          best_age = age[i];
        end
      end
      if (slot_free[k] && found && !flush) begin
        sel_valid[k]     = 1'b1;
        sel_id[k]        = RS_W'(best);
        sel_tag[k]       = rs_tag[best*TAG_W +: TAG_W];
        sel_lsq[k]       = (rs_is_load[best] || rs_is_store[best]) ?
                           rs_lsq_id[best*LSQ_W +: LSQ_W] : '0;
        pool[best]       = 1'b0;
        rs_grant_d[best] = 1'b1;
      end
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      iss_rs_id_d[k]  = iss_rs_id_q[k];
      iss_tag_d[k]    = iss_tag_q[k];
      iss_lsq_id_d[k] = iss_lsq_id_q[k];
      if (flush) begin
        iss_valid_d[k] = 1'b0;
      end else if (slot_free[k]) begin
        iss_valid_d[k] = sel_valid[k];
        if (sel_valid[k]) begin
          iss_rs_id_d[k]  = sel_id[k];
          iss_tag_d[k]    = sel_tag[k];
          iss_lsq_id_d[k] = sel_lsq[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_valid_q <= '0;
      rs_grant_q  <= '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        iss_rs_id_q[k]  <= '0;
        iss_tag_q[k]    <= '0;
        iss_lsq_id_q[k] <= '0;
      end
    end else begin
      iss_valid_q <= iss_valid_d;
      rs_grant_q  <= rs_grant_d;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        iss_rs_id_q[k]  <= iss_rs_id_d[k];
        iss_tag_q[k]    <= iss_tag_d[k];
        iss_lsq_id_q[k] <= iss_lsq_id_d[k];
      end
    end
  end

  assign iss_valid = iss_valid_q;
  assign rs_grant  = rs_grant_q;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_out
    assign iss_rs_id[k*RS_W +: RS_W]    = iss_rs_id_q[k];
    assign iss_tag[k*TAG_W +: TAG_W]    = iss_tag_q[k];
    assign iss_lsq_id[k*LSQ_W +: LSQ_W] = iss_lsq_id_q[k];
  end

`ifdef ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters wrap freely and deliberately ignore flush.
  always_comb begin
    perf_issued_d = perf_issued_q + 32'($countones(iss_valid_q & iss_ready));
    perf_stall_d  = perf_stall_q + {31'b0, |(iss_valid_q & ~iss_ready)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_issue_select_multi.sv
// Bench for issue_select_multi: table of single-cycle vectors plus hand-written stall,
// double-issue, flush and async-reset sequences, checked through an expectation queue.
module tb_issue_select_multi;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [7:0]  rs_ready;
  logic [31:0] rs_tag;
  logic [23:0] rs_lsq_id;
  logic [7:0]  rs_is_load;
  logic [7:0]  rs_is_store;
  logic [3:0]  rob_head;
  logic [15:0] rob_ctrl_mask;
  logic [2:0]  lsq_head;
  logic [7:0]  lsq_store_mask;
  logic [1:0]  iss_ready;
  logic [1:0]  iss_valid;
  logic [5:0]  iss_rs_id;
  logic [7:0]  iss_tag;
  logic [5:0]  iss_lsq_id;
  logic [7:0]  rs_grant;
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;

  issue_select_multi dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rs_ready(rs_ready), .rs_tag(rs_tag), .rs_lsq_id(rs_lsq_id),
    .rs_is_load(rs_is_load), .rs_is_store(rs_is_store),
    .rob_head(rob_head), .rob_ctrl_mask(rob_ctrl_mask),
    .lsq_head(lsq_head), .lsq_store_mask(lsq_store_mask),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_rs_id(iss_rs_id),
    .iss_tag(iss_tag), .iss_lsq_id(iss_lsq_id), .rs_grant(rs_grant),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0]      ready, ld, st;
    logic [31:0]     tags;
    logic [23:0]     lsqs;
    logic [3:0]      head;
    logic [15:0]     ctrl;
    logic [2:0]      lhead;
    logic [7:0]      smask;
    logic [1:0]      iready;
    logic            flush;
    logic [1:0]      ev;
    logic [1:0][2:0] eid;
    logic [1:0][3:0] etag;
    logic [1:0][2:0] elsq;
    logic [7:0]      egnt;
  } vec_t;

  typedef struct {
    string           name;
    logic [1:0]      ev;
    logic [1:0][2:0] eid;
    logic [1:0][3:0] etag;
    logic [1:0][2:0] elsq;
    logic [7:0]      egnt;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t blank(string n);
    vec_t v;
    v.name = n;   v.ready = '0; v.ld = '0;    v.st = '0;
    v.tags = '0;  v.lsqs = '0;  v.head = '0;  v.ctrl = '0;
    v.lhead = '0; v.smask = '0; v.iready = 2'b11; v.flush = 1'b0;
    v.ev = '0;    v.eid = '0;   v.etag = '0;  v.elsq = '0; v.egnt = '0;
    return v;
  endfunction

  function automatic vec_t alu(vec_t v, int i, int t);
    v.ready[i] = 1'b1;
    v.tags[i*4 +: 4] = 4'(t);
    return v;
  endfunction

  function automatic vec_t ld(vec_t v, int i, int t, int l);
    v = alu(v, i, t);
    v.ld[i] = 1'b1;
    v.lsqs[i*3 +: 3] = 3'(l);
    return v;
  endfunction

  function automatic vec_t st(vec_t v, int i, int t, int l);
    v = alu(v, i, t);
    v.st[i] = 1'b1;
    v.lsqs[i*3 +: 3] = 3'(l);
    return v;
  endfunction

  // granted=0 marks a slot that is merely held from an earlier cycle.
  function automatic vec_t slot(vec_t v, int k, int id, int t, int l, bit granted);
    v.ev[k] = 1'b1;
    v.eid[k] = 3'(id);
    v.etag[k] = 4'(t);
    v.elsq[k] = 3'(l);
    if (granted) v.egnt[id] = 1'b1;
    return v;
  endfunction

  task automatic cmp(string nm, string what, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s/%s: got 0x%0h expected 0x%0h", nm, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    flush = v.flush;          rs_ready = v.ready;
    rs_tag = v.tags;          rs_lsq_id = v.lsqs;
    rs_is_load = v.ld;        rs_is_store = v.st;
    rob_head = v.head;        rob_ctrl_mask = v.ctrl;
    lsq_head = v.lhead;       lsq_store_mask = v.smask;
    iss_ready = v.iready;
    e.name = v.name; e.ev = v.ev; e.eid = v.eid;
    e.etag = v.etag; e.elsq = v.elsq; e.egnt = v.egnt;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      cmp("scoreboard", "queue_depth", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      cmp(e.name, "iss_valid", 32'(iss_valid), 32'(e.ev));
      for (int k = 0; k < 2; k++) begin
        if (e.ev[k]) begin
          cmp(e.name, $sformatf("rs_id%0d", k), 32'(iss_rs_id[k*3 +: 3]), 32'(e.eid[k]));
          cmp(e.name, $sformatf("tag%0d", k), 32'(iss_tag[k*4 +: 4]), 32'(e.etag[k]));
          cmp(e.name, $sformatf("lsq%0d", k), 32'(iss_lsq_id[k*3 +: 3]), 32'(e.elsq[k]));
        end
      end
      cmp(e.name, "rs_grant", 32'(rs_grant), 32'(e.egnt));
    end
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] p0;

    tbl.push_back(slot(slot(alu(alu(blank("two_alu"), 3, 5), 6, 2), 0, 6, 2, 0, 1), 1, 3, 5, 0, 1));
    v = alu(alu(blank("rob_wrap"), 1, 1), 4, 15); v.head = 4'd14;
    tbl.push_back(slot(slot(v, 0, 4, 15, 0, 1), 1, 1, 1, 0, 1));
    v = ld(blank("load_blocked_st"), 2, 3, 3); v.lhead = 3'd1; v.smask = 8'h04;
    tbl.push_back(v);
    v = ld(blank("load_free"), 2, 3, 3); v.lhead = 3'd1;
    tbl.push_back(slot(v, 0, 2, 3, 3, 1));
    v = st(blank("store_not_head"), 5, 4, 2); v.lhead = 3'd1;
    tbl.push_back(v);
    v = st(blank("store_at_head"), 5, 4, 2); v.lhead = 3'd2;
    tbl.push_back(slot(v, 0, 5, 4, 2, 1));
    v = alu(ld(blank("load_blocked_ctrl"), 0, 6, 0), 1, 9); v.ctrl = 16'h0008;
    tbl.push_back(slot(v, 0, 1, 9, 0, 1));
    v = alu(alu(ld(blank("mem_older"), 0, 2, 1), 7, 3), 4, 8); v.lhead = 3'd1;
    tbl.push_back(slot(slot(v, 0, 0, 2, 1, 1), 1, 7, 3, 0, 1));
    v = alu(ld(alu(blank("alu_older"), 2, 1), 5, 4, 0), 6, 7);
    tbl.push_back(slot(slot(v, 0, 2, 1, 0, 1), 1, 6, 7, 0, 1));
    v = ld(st(blank("one_mem_per_cycle"), 0, 3, 4), 1, 5, 4); v.lhead = 3'd4;
    tbl.push_back(slot(v, 0, 0, 3, 4, 1));
    tbl.push_back(blank("empty_rs"));
    v = ld(blank("ctrl_range_excl"), 3, 7, 0); v.ctrl = 16'h0180;
    tbl.push_back(slot(v, 0, 3, 7, 0, 1));
    v = alu(ld(blank("ctrl_wrap"), 2, 0, 0), 6, 1); v.head = 4'd14; v.ctrl = 16'h8000;
    tbl.push_back(slot(v, 0, 6, 1, 0, 1));
    v = ld(blank("lsq_wrap_blocked"), 4, 2, 1); v.lhead = 3'd6; v.smask = 8'h80;
    tbl.push_back(v);
    v = ld(blank("lsq_wrap_free"), 4, 2, 1); v.lhead = 3'd6; v.smask = 8'h02;
    tbl.push_back(slot(v, 0, 4, 2, 1, 1));
    v = alu(alu(alu(blank("three_alu"), 0, 4), 1, 2), 2, 9);
    tbl.push_back(slot(slot(v, 0, 1, 2, 0, 1), 1, 0, 4, 0, 1));

    reset = 1'b0;
    flush = 1'b0; rs_ready = '0; rs_tag = '0; rs_lsq_id = '0;
    rs_is_load = '0; rs_is_store = '0; rob_head = '0; rob_ctrl_mask = '0;
    lsq_head = '0; lsq_store_mask = '0; iss_ready = 2'b11;
    repeat (2) @(negedge clk);
    cmp("reset", "iss_valid", 32'(iss_valid), 32'd0);
    cmp("reset", "rs_grant", 32'(rs_grant), 32'd0);
    cmp("reset", "iss_tag", 32'(iss_tag), 32'd0);
    cmp("reset", "perf_stall", perf_stall, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i]);
      run(blank("drain"));
    end

    // A grant still visible in the next cycle must not re-issue the same entry.
    run(slot(alu(blank("guard_a"), 0, 2), 0, 0, 2, 0, 1));
    run(alu(blank("guard_b"), 0, 2));
    run(blank("drain"));

    // Slot 0 stalls three cycles; ALU work flows through slot 1, the load waits.
    run(slot(alu(blank("stall_1"), 0, 1), 0, 0, 1, 0, 1));
    p0 = perf_stall;
    v = alu(ld(blank("stall_2"), 1, 3, 0), 2, 5); v.iready = 2'b10;
    run(slot(slot(v, 0, 0, 1, 0, 0), 1, 2, 5, 0, 1));
    v = alu(ld(blank("stall_3"), 1, 3, 0), 3, 6); v.iready = 2'b10;
    run(slot(slot(v, 0, 0, 1, 0, 0), 1, 3, 6, 0, 1));
    v = ld(blank("stall_4"), 1, 3, 0); v.iready = 2'b10;
    run(slot(v, 0, 0, 1, 0, 0));
`ifdef ISSUE_PERF_EN
    cmp("stall", "perf_stall_delta", perf_stall - p0, 32'd3);
`else
    cmp("stall", "perf_stall_tied", perf_stall, 32'd0);
`endif
    run(slot(ld(blank("stall_release"), 1, 3, 0), 0, 1, 3, 0, 1));
    run(blank("drain"));

    // Flush with both slots stalled-valid, then async reset in the middle of a stall.
    v = alu(alu(blank("flush_fill"), 0, 1), 1, 2); v.iready = 2'b00;
    run(slot(slot(v, 0, 0, 1, 0, 1), 1, 1, 2, 0, 1));
    v = alu(blank("flush_hold"), 2, 3); v.iready = 2'b00;
    run(slot(slot(v, 0, 0, 1, 0, 0), 1, 1, 2, 0, 0));
    v = alu(blank("flush"), 2, 3); v.iready = 2'b00; v.flush = 1'b1;
    run(v);
    v = alu(blank("post_flush"), 2, 3); v.iready = 2'b00;
    run(slot(v, 0, 2, 3, 0, 1));
    rs_ready = '0;
    #2 reset = 1'b0;
    #1;
    cmp("async_reset", "iss_valid", 32'(iss_valid), 32'd0);
    cmp("async_reset", "rs_grant", 32'(rs_grant), 32'd0);
    cmp("async_reset", "iss_tag", 32'(iss_tag), 32'd0);
    cmp("async_reset", "iss_rs_id", 32'(iss_rs_id), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    cmp("end", "scoreboard_left", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_select_multi.md
Name: issue_select_multi

Overview:
- Parametrised multi-issue successor to the single-issue stage.
- Each cycle it selects up to ISSUE_WIDTH ready reservation-station entries, oldest first by ROB age, with wrap-around handled.
- Enforces memory ordering: loads wait for older stores and older control ops; stores issue only at the LSQ head.
- Selections are held in per-slot output registers with a valid/ready handshake towards execute; the granted station gets a one-cycle release pulse.

Parameters:
- ISSUE_WIDTH, 2, number of issue slots; slot 0 is the only slot allowed to carry memory ops.
- RS_SIZE, 8, reservation-station entries.
- ROB_SIZE, 16, ROB entries; power of 2.
- LSQ_SIZE, 8, LSQ entries; power of 2.
- RS_W, $clog2(RS_SIZE), station index width.
- TAG_W, $clog2(ROB_SIZE), ROB tag width; tags are 0-based.
- LSQ_W, $clog2(LSQ_SIZE), LSQ index width; indices are 0-based.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash from branch recovery.
- rs_ready  in  RS_SIZE  entry busy and both source tags resolved.
- rs_tag  in  RS_SIZE*TAG_W  ROB tag per entry, flattened (entry i at [i*TAG_W +: TAG_W]).
- rs_lsq_id  in  RS_SIZE*LSQ_W  LSQ index per entry, flattened.
- rs_is_load  in  RS_SIZE  entry is a load.
- rs_is_store  in  RS_SIZE  entry is a store.
- rob_head  in  TAG_W  oldest ROB entry.
- rob_ctrl_mask  in  ROB_SIZE  bit t = ROB entry t is an unresolved jump/branch.
- lsq_head  in  LSQ_W  oldest LSQ entry.
- lsq_store_mask  in  LSQ_SIZE  bit j = LSQ entry j is an uncommitted store.
- iss_ready  in  ISSUE_WIDTH  execute slot k accepts this cycle.
- iss_valid  out  ISSUE_WIDTH  slot k holds an issued op.
- iss_rs_id  out  ISSUE_WIDTH*RS_W  station index per slot.
- iss_tag  out  ISSUE_WIDTH*TAG_W  ROB tag per slot.
- iss_lsq_id  out  ISSUE_WIDTH*LSQ_W  LSQ index per slot; 0 for non-memory ops.
- rs_grant  out  RS_SIZE  one-cycle pulse; the station owner clears entry i on the same edge.

Behaviour:
- Reset (reset=0, asynchronous): iss_valid=0, all iss_* fields=0, rs_grant=0, perf counters=0.
- Age of an op: (tag - rob_head) mod ROB_SIZE; smaller is older. Ties are impossible because tags are unique.
- Slot k is free when !iss_valid[k] || iss_ready[k].
  - A free slot with no new selection drops iss_valid[k] at the next edge.
  - A stalled slot (valid && !ready) keeps all its fields stable.
- Candidate = rs_ready[i] && !rs_grant[i]; the second term guards against double issue.
- Load eligibility:
  - No set lsq_store_mask bit in the range [lsq_head, rs_lsq_id) modulo LSQ_SIZE.
  - No set rob_ctrl_mask bit in the range [rob_head, rs_tag) modulo ROB_SIZE.
- Store eligibility: rs_lsq_id == lsq_head, and the same rob_ctrl_mask check as loads.
- Memory ops go only to slot 0, and at most one memory op issues per cycle. A memory op is selected only when slot 0 is free.
- Non-memory ops fill the free slots in ascending slot order, oldest first. Slot 0 takes a non-memory op only when no eligible memory op is older than it.
- Selection is combinational from inputs. Results register at the edge; rs_grant for the chosen entries is asserted in the same cycle (registered, latency 1 from rs_ready to iss_valid).
- flush=1: next edge clears iss_valid; rs_grant is forced to 0 during that cycle. Flush has priority over new selection.
- Empty station array: no grants, and free slots go invalid. Full ROB wrap (rob_head > tag): the modular age rule applies unchanged.

Optional Feature:
- ISSUE_PERF_EN defined adds two free-running wrapping counters, exposed on ports perf_issued (32, out) and perf_stall (32, out):
  - perf_issued += number of slots with iss_valid && iss_ready each cycle.
  - perf_stall += 1 each cycle in which any slot has valid && !ready.
- Both counters are cleared by reset and are not affected by flush.
- Undefined: the ports remain but are tied to 0, and no counter flops exist.

Test Plan:
1. Two ALU entries: tag 5 (station 3) and tag 2 (station 6), rob_head=0, iss_ready=11 -> next cycle slot0 holds rs_id 6/tag 2, slot1 holds rs_id 3/tag 5; rs_grant=0x48 for one cycle.
2. Wrap: rob_head=14, ready entries with tags 1 and 15 -> tag 15 issues in slot0 and tag 1 in slot1.
3. Load at lsq_id 3, lsq_head=1, lsq_store_mask=0x04 -> load blocked. Clear the mask to 0 -> load issues in slot0 next cycle.
4. Store at lsq_id 2 with lsq_head=1 -> not issued. Set lsq_head=2 -> store issues with iss_lsq_id=2.
5. Slot0 valid and iss_ready=0 for 3 cycles while new entries arrive -> slot0 fields stable, no memory op granted, ALU ops use slot1. With ISSUE_PERF_EN, perf_stall increments by 3.
6. flush pulsed with both slots valid -> both iss_valid=0 next edge and rs_grant=0 that cycle. Async reset mid-stall -> all outputs 0 immediately.
